// File: rtl/ahb_dly_pkg.sv
// Shared types and constants for the AHB master-to-slave cycle delay line.
package ahb_dly_pkg;

    localparam int unsigned CTRL_W = 16;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef struct packed {
        logic       hsel;
        logic       hready_ba;
        logic       hwrite;
        logic       hmastlock;
        logic [1:0] htrans;
        logic [2:0] hsize;
        logic [2:0] hburst;
        logic [3:0] hmaster;
    } ahb_ctrl_t;

    // Control part of the bundle driven when no captured entry is due; address and data idle at zero
    localparam ahb_ctrl_t IDLE_BUNDLE = '{
        hsel:      1'b0,
        hready_ba: 1'b1,
        hwrite:    1'b0,
        hmastlock: 1'b0,
        htrans:    HTRANS_IDLE,
        hsize:     3'b010,
        hburst:    3'b000,
        hmaster:   4'h0
    };

    typedef enum logic {
        RUN  = 1'b0,
        FILL = 1'b1
    } dly_state_e;

    function automatic int unsigned bundle_w(input int unsigned hamax, input int unsigned hdmax);
        return CTRL_W + hamax + hdmax;
    endfunction

endpackage

// File: rtl/ahb_dly_ram.sv
// Delay-line storage: one write port, asynchronous read, per-entry valid bits with clear-all.
module ahb_dly_ram
    import ahb_dly_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 80,
    parameter int unsigned AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata_c,
    output logic          o_rvalid_c
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // A write in the clearing cycle survives the clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else begin
            if (i_clr) begin
                r_valid <= '0;
            end
            if (i_we) begin
                r_valid[i_waddr] <= 1'b1;
            end
        end
    end

    assign o_rdata_c  = r_mem[i_raddr];
    assign o_rvalid_c = r_valid[i_raddr];

endmodule

// File: rtl/ahb_cycle_delay.sv
// Run-time selectable whole-cycle delay line for the AHB master-to-slave bundle.
module ahb_cycle_delay
    import ahb_dly_pkg::*;
#(
    parameter int unsigned HAMAX   = 32,
    parameter int unsigned HDMAX   = 32,
    parameter int unsigned MAXDLY  = 8,
    parameter int unsigned DLY_RST = 1,
    localparam int unsigned DW     = $clog2(MAXDLY + 1)
) (
    input  logic             hclk,
    input  logic             hrst,
    input  logic             hsel,
    input  logic             hready_ba,
    input  logic             hwrite,
    input  logic             hmastlock,
    input  logic [HAMAX-1:0] haddr,
    input  logic [1:0]       htrans,
    input  logic [2:0]       hsize,
    input  logic [2:0]       hburst,
    input  logic [HDMAX-1:0] hwdata,
    input  logic [3:0]       hmaster,
    input  logic [DW-1:0]    dly_sel,
    input  logic             dly_load,
    output logic             hsel_d,
    output logic             hready_ba_d,
    output logic             hwrite_d,
    output logic             hmastlock_d,
    output logic [HAMAX-1:0] haddr_d,
    output logic [1:0]       htrans_d,
    output logic [2:0]       hsize_d,
    output logic [2:0]       hburst_d,
    output logic [HDMAX-1:0] hwdata_d,
    output logic [3:0]       hmaster_d,
    output logic [DW-1:0]    dly_cur,
    output logic             dly_busy
);

    localparam int unsigned W  = bundle_w(HAMAX, HDMAX);
    localparam int unsigned AW = (MAXDLY > 1) ? $clog2(MAXDLY) : 1;

    logic [AW-1:0] r_wptr;
    logic [DW-1:0] r_dly_cur;
    logic [DW-1:0] r_fcnt;
    dly_state_e    r_state;

    ahb_ctrl_t     w_in_ctrl;
    logic [W-1:0]  w_in;
    logic [W-1:0]  w_rdata;
    logic          w_rvalid;
    logic [W-1:0]  w_out;
    ahb_ctrl_t     w_out_ctrl;
    logic [AW:0]   w_rsum;
    logic [AW-1:0] w_ridx;
    logic [DW-1:0] w_dly_clamp;

    assign w_in_ctrl = '{
        hsel:      hsel,
        hready_ba: hready_ba,
        hwrite:    hwrite,
        hmastlock: hmastlock,
        htrans:    htrans,
        hsize:     hsize,
        hburst:    hburst,
        hmaster:   hmaster
    };
    assign w_in = {w_in_ctrl, haddr, hwdata};

    // Read index (wptr - dly_cur) mod MAXDLY; the sum never goes negative since dly_cur <= MAXDLY
    assign w_rsum = {1'b0, r_wptr} + (AW+1)'(MAXDLY) - (AW+1)'(r_dly_cur);
    assign w_ridx = (w_rsum >= (AW+1)'(MAXDLY)) ? AW'(w_rsum - (AW+1)'(MAXDLY)) : AW'(w_rsum);

    assign w_dly_clamp = (32'(dly_sel) > MAXDLY) ? DW'(MAXDLY) : dly_sel;

    ahb_dly_ram #(
        .DEPTH (MAXDLY),
        .W     (W),
        .AW    (AW)
    ) u_ram (
        .i_clk      (hclk),
        .i_rst      (hrst),
        .i_clr      (dly_load),
        .i_we       (~hrst),
        .i_waddr    (r_wptr),
        .i_wdata    (w_in),
        .i_raddr    (w_ridx),
        .o_rdata_c  (w_rdata),
        .o_rvalid_c (w_rvalid)
    );

    // Pointer, delay setting and fill-tracking FSM
    always_ff @(posedge hclk) begin
        if (hrst) begin
            r_wptr    <= '0;
            r_dly_cur <= DW'(DLY_RST);
            r_fcnt    <= '0;
            r_state   <= FILL;
        end else begin
            r_wptr <= (r_wptr == AW'(MAXDLY - 1)) ? '0 : r_wptr + AW'(1);
            if (dly_load) begin
                r_dly_cur <= w_dly_clamp;
                r_fcnt    <= '0;
                r_state   <= FILL;
            end else if (r_state == FILL) begin
                if (32'(r_fcnt) + 32'd1 >= 32'(r_dly_cur)) begin
                    r_fcnt  <= '0;
                    r_state <= RUN;
                end else begin
                    r_fcnt <= r_fcnt + DW'(1);
                end
            end
        end
    end

    // Zero delay bypasses the buffer; otherwise empty slots read as the idle bundle
    always_comb begin
        w_out = {IDLE_BUNDLE, HAMAX'(0), HDMAX'(0)};
        if (r_dly_cur == '0) begin
            w_out = w_in;
        end else if (w_rvalid) begin
            w_out = w_rdata;
        end
    end

    assign {w_out_ctrl, haddr_d, hwdata_d} = w_out;

    assign hsel_d      = w_out_ctrl.hsel;
    assign hready_ba_d = w_out_ctrl.hready_ba;
    assign hwrite_d    = w_out_ctrl.hwrite;
    assign hmastlock_d = w_out_ctrl.hmastlock;
    assign htrans_d    = w_out_ctrl.htrans;
    assign hsize_d     = w_out_ctrl.hsize;
    assign hburst_d    = w_out_ctrl.hburst;
    assign hmaster_d   = w_out_ctrl.hmaster;
    assign dly_cur     = r_dly_cur;
    assign dly_busy    = (r_state == FILL);

endmodule

// File: tb/tb_ahb_cycle_delay.sv
// Self-checking bench for ahb_cycle_delay against a cycle-history reference model.
module tb_ahb_cycle_delay;

    localparam int unsigned MAXDLY  = 8;
    localparam int unsigned DLY_RST = 1;
    localparam int unsigned DW      = 4;

    typedef struct packed {
        logic        hsel;
        logic        hready_ba;
        logic        hwrite;
        logic        hmastlock;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic [3:0]  hmaster;
        logic [31:0] haddr;
        logic [31:0] hwdata;
    } bus_t;

    localparam bus_t IDLE = '{
        hsel: 1'b0, hready_ba: 1'b1, hwrite: 1'b0, hmastlock: 1'b0,
        htrans: 2'b00, hsize: 3'b010, hburst: 3'b000, hmaster: 4'h0,
        haddr: 32'h0, hwdata: 32'h0
    };

    logic          hclk = 1'b0;
    logic          hrst;
    logic          dly_load;
    logic [DW-1:0] dly_sel;
    bus_t          drv;
    bus_t          obs;

    logic          hsel_d, hready_ba_d, hwrite_d, hmastlock_d;
    logic [31:0]   haddr_d, hwdata_d;
    logic [1:0]    htrans_d;
    logic [2:0]    hsize_d, hburst_d;
    logic [3:0]    hmaster_d;
    logic [DW-1:0] dly_cur;
    logic          dly_busy;

    int   checks;
    int   failures;
    int   t;
    int   start;
    int   dcur;
    int   busy_cnt;
    bit   armed;
    bus_t hist [0:4095];

    always #5 hclk = ~hclk;

    ahb_cycle_delay #(
        .HAMAX   (32),
        .HDMAX   (32),
        .MAXDLY  (MAXDLY),
        .DLY_RST (DLY_RST)
    ) dut (
        .hclk        (hclk),
        .hrst        (hrst),
        .hsel        (drv.hsel),
        .hready_ba   (drv.hready_ba),
        .hwrite      (drv.hwrite),
        .hmastlock   (drv.hmastlock),
        .haddr       (drv.haddr),
        .htrans      (drv.htrans),
        .hsize       (drv.hsize),
        .hburst      (drv.hburst),
        .hwdata      (drv.hwdata),
        .hmaster     (drv.hmaster),
        .dly_sel     (dly_sel),
        .dly_load    (dly_load),
        .hsel_d      (hsel_d),
        .hready_ba_d (hready_ba_d),
        .hwrite_d    (hwrite_d),
        .hmastlock_d (hmastlock_d),
        .haddr_d     (haddr_d),
        .htrans_d    (htrans_d),
        .hsize_d     (hsize_d),
        .hburst_d    (hburst_d),
        .hwdata_d    (hwdata_d),
        .hmaster_d   (hmaster_d),
        .dly_cur     (dly_cur),
        .dly_busy    (dly_busy)
    );

    always_comb begin
        obs = '{
            hsel: hsel_d, hready_ba: hready_ba_d, hwrite: hwrite_d, hmastlock: hmastlock_d,
            htrans: htrans_d, hsize: hsize_d, hburst: hburst_d, hmaster: hmaster_d,
            haddr: haddr_d, hwdata: hwdata_d
        };
    end

    function automatic bus_t rnd_bus();
        bus_t b;
        b.hsel      = 1'($urandom);
        b.hready_ba = 1'($urandom);
        b.hwrite    = 1'($urandom);
        b.hmastlock = 1'($urandom);
        b.htrans    = 2'($urandom);
        b.hsize     = 3'($urandom);
        b.hburst    = 3'($urandom);
        b.hmaster   = 4'($urandom);
        b.haddr     = $urandom;
        b.hwdata    = $urandom;
        return b;
    endfunction

    function automatic bus_t nonseq_bus();
        bus_t b;
        b        = rnd_bus();
        b.htrans = 2'b10;
        return b;
    endfunction

    // One bus cycle: drive, check against the model, then advance the model across the edge
    task automatic cycle(input bus_t b, input logic ld, input int sel, input logic rst);
        bus_t exp_b;
        drv      = b;
        dly_load = ld;
        dly_sel  = DW'(sel);
        hrst     = rst;
        #1;
        if (armed) begin
            if (dcur == 0)               exp_b = b;
            else if (t - dcur >= start)  exp_b = hist[t - dcur];
            else                         exp_b = IDLE;
            checks++;
            assert (obs === exp_b) else begin
                failures++;
                $error("FAIL bundle t=%0d observed=%h expected=%h", t, obs, exp_b);
            end
            checks++;
            assert (32'(dly_cur) === 32'(dcur)) else begin
                failures++;
                $error("FAIL dly_cur t=%0d observed=%0d expected=%0d", t, dly_cur, dcur);
            end
            checks++;
            assert (dly_busy === (busy_cnt > 0)) else begin
                failures++;
                $error("FAIL dly_busy t=%0d observed=%b expected=%b", t, dly_busy, busy_cnt > 0);
            end
        end
        hist[t] = b;
        @(posedge hclk);
        #1;
        if (rst) begin
            dcur     = DLY_RST;
            start    = t + 1;
            busy_cnt = (dcur > 0) ? dcur : 1;
            armed    = 1'b1;
        end else if (ld) begin
            dcur     = (sel > int'(MAXDLY)) ? int'(MAXDLY) : sel;
            start    = t;
            busy_cnt = (dcur > 0) ? dcur : 1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        t++;
    endtask

    initial begin
        bus_t b;
        checks   = 0;
        failures = 0;
        t        = 0;
        start    = 0;
        dcur     = 0;
        busy_cnt = 0;
        armed    = 1'b0;
        drv      = IDLE;
        hrst     = 1'b1;
        dly_load = 1'b0;
        dly_sel  = '0;

        repeat (2) cycle(rnd_bus(), 1'b0, 0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            b       = rnd_bus();
            b.haddr = 32'h100 + 32'(4 * k);
            cycle(b, 1'b0, 0, 1'b0);
        end

        cycle(rnd_bus(), 1'b1, 5, 1'b0);
        repeat (12) cycle(rnd_bus(), 1'b0, 0, 1'b0);

        cycle(rnd_bus(), 1'b1, 0, 1'b0);
        repeat (6) cycle(rnd_bus(), 1'b0, 0, 1'b0);

        cycle(rnd_bus(), 1'b1, MAXDLY + 3, 1'b0);
        repeat (3 * MAXDLY + 4) cycle(rnd_bus(), 1'b0, 0, 1'b0);

        cycle(rnd_bus(), 1'b1, 4, 1'b0);
        cycle(rnd_bus(), 1'b0, 0, 1'b0);
        cycle(rnd_bus(), 1'b1, 2, 1'b0);
        repeat (8) cycle(rnd_bus(), 1'b0, 0, 1'b0);

        cycle(nonseq_bus(), 1'b1, 3, 1'b0);
        repeat (6) cycle(nonseq_bus(), 1'b0, 0, 1'b0);
        cycle(nonseq_bus(), 1'b1, 6, 1'b1);
        repeat (8) cycle(nonseq_bus(), 1'b0, 0, 1'b0);

        cycle(rnd_bus(), 1'b1, 3, 1'b0);
        repeat (4) cycle(rnd_bus(), 1'b0, 0, 1'b0);
        cycle(rnd_bus(), 1'b1, 3, 1'b0);
        repeat (5) cycle(rnd_bus(), 1'b0, 0, 1'b0);

        repeat (100) begin
            cycle(rnd_bus(), 1'(($urandom % 8) == 0), int'($urandom_range(0, 15)),
                  1'(($urandom % 40) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
